// File: rtl/hazard_scoreboard_ctrl_if.sv
// ID-stage request and pipeline-control bundle between the datapath and
// the hazard scoreboard controller.
interface hazard_scoreboard_ctrl_if #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_reg_write;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_branch_taken;
  logic                  stall_if;
  logic                  bubble_ex;
  logic                  flush_if_id;
  logic                  issue;
  logic [NUM_REGS-1:0]   busy_mask;
  logic [15:0]           stall_count;
  logic [1:0]            state;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_rd, ex_branch_taken,
    input  stall_if, bubble_ex, flush_if_id, issue, busy_mask,
           stall_count, state
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_rd, ex_branch_taken,
    output stall_if, bubble_ex, flush_if_id, issue, busy_mask,
           stall_count, state
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// 5-stage pipeline sequencer: countdown scoreboard for in-flight register
// writes, RAW stall/bubble generation and taken-branch squash.
module hazard_scoreboard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int WB_LATENCY   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_scoreboard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [2:0] LOAD_VAL  = 3'(WB_LATENCY);
  localparam logic [1:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_t              state_q, state_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic [2:0]          cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                hazard;
  logic                rs_hit, rt_hit;
  logic [15:0]         stall_cnt_q;
  logic                load;

  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      busy[r] = (cnt[r] != 3'd0);
    end
  end

  always_comb begin
    rs_hit = bus.id_uses_rs && (bus.id_rs != '0) && busy[bus.id_rs];
    rt_hit = bus.id_uses_rt && (bus.id_rt != '0) && busy[bus.id_rt];
    hazard = bus.id_valid && (rs_hit || rt_hit);
  end

  assign load = bus.issue && bus.id_reg_write && (bus.id_rd != '0);

  // A new writer reloads its counter even when an older write is still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (load && (bus.id_rd == REG_ADDR_W'(r))) begin
          cnt[r] <= LOAD_VAL;
        end else if (cnt[r] != 3'd0) begin
          cnt[r] <= cnt[r] - 3'd1;
        end
      end
      cnt[0] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    bus.stall_if    = 1'b0;
    bus.bubble_ex   = 1'b0;
    bus.flush_if_id = 1'b0;
    bus.issue       = 1'b0;

    if (reset) begin
      bus.bubble_ex = 1'b1;
    end else if (state_q == FLUSH) begin
      bus.flush_if_id = 1'b1;
      bus.bubble_ex   = 1'b1;
      if (fcnt_q == 2'd0) begin
        state_d = RUN;
      end else begin
        fcnt_d = fcnt_q - 2'd1;
      end
    end else if (bus.ex_branch_taken) begin
      // The branch cycle itself is the first squash cycle.
      bus.flush_if_id = 1'b1;
      bus.bubble_ex   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FCNT_INIT;
      end else begin
        state_d = RUN;
      end
    end else if (hazard) begin
      bus.stall_if  = 1'b1;
      bus.bubble_ex = 1'b1;
      state_d       = STALL;
    end else begin
      bus.issue     = bus.id_valid;
      bus.bubble_ex = ~bus.id_valid;
      state_d       = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (bus.stall_if && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.busy_mask   = busy;
  assign bus.stall_count = stall_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl with hand-computed expectations.
module tb_hazard_scoreboard_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_scoreboard_ctrl_if #(.NUM_REGS(32), .REG_ADDR_W(5)) bus ();

  hazard_scoreboard_ctrl #(
    .NUM_REGS    (32),
    .REG_ADDR_W  (5),
    .WB_LATENCY  (3),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // valid, rs, rt, uses_rs, uses_rt, reg_write, rd, branch_taken
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw,
                       input logic [4:0] rd, input logic br);
    bus.id_valid        = v;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rs      = urs;
    bus.id_uses_rt      = urt;
    bus.id_reg_write    = rw;
    bus.id_rd           = rd;
    bus.ex_branch_taken = br;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held two cycles with a writing instruction presented
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 3, 0);
    chk("rst0_issue", 32'(bus.issue), 32'd0);
    chk("rst0_bubble", 32'(bus.bubble_ex), 32'd1);
    chk("rst0_stall", 32'(bus.stall_if), 32'd0);
    next_cycle();
    chk("rst1_issue", 32'(bus.issue), 32'd0);
    chk("rst1_flush", 32'(bus.flush_if_id), 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", 32'(bus.busy_mask), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_scount", 32'(bus.stall_count), 32'd0);
    chk("idle_bubble", 32'(bus.bubble_ex), 32'd1);

    // RAW on r8: producer cycle 0, consumer stalls cycles 1-3, issues cycle 4
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 8, 0);
    chk("raw8_prod_issue", 32'(bus.issue), 32'd1);
    next_cycle();
    drive(1, 8, 0, 1, 0, 0, 0, 0);
    chk("raw8_c1_stall", 32'(bus.stall_if), 32'd1);
    chk("raw8_c1_bubble", 32'(bus.bubble_ex), 32'd1);
    chk("raw8_c1_issue", 32'(bus.issue), 32'd0);
    chk("raw8_c1_busy", 32'(bus.busy_mask), 32'h0000_0100);
    chk("raw8_c1_state", 32'(bus.state), 32'd0);
    next_cycle();
    chk("raw8_c2_stall", 32'(bus.stall_if), 32'd1);
    chk("raw8_c2_state", 32'(bus.state), 32'd1);
    next_cycle();
    chk("raw8_c3_stall", 32'(bus.stall_if), 32'd1);
    next_cycle();
    chk("raw8_c4_stall", 32'(bus.stall_if), 32'd0);
    chk("raw8_c4_issue", 32'(bus.issue), 32'd1);
    chk("raw8_c4_busy", 32'(bus.busy_mask), 32'd0);
    chk("raw8_c4_scount", 32'(bus.stall_count), 32'd3);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("raw8_end_state", 32'(bus.state), 32'd0);

    // r0 is never tracked
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    chk("r0_prod_issue", 32'(bus.issue), 32'd1);
    next_cycle();
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    chk("r0_cons_stall", 32'(bus.stall_if), 32'd0);
    chk("r0_cons_issue", 32'(bus.issue), 32'd1);
    chk("r0_busy", 32'(bus.busy_mask), 32'd0);

    // WAW on r5: second writer reloads, busy cycles 1-4
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 5, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 5, 0);
    chk("waw_c1_busy", 32'(bus.busy_mask), 32'h0000_0020);
    chk("waw_c1_issue", 32'(bus.issue), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("waw_c%0d_busy", c), 32'(bus.busy_mask), 32'h0000_0020);
    end
    next_cycle();
    chk("waw_c5_busy", 32'(bus.busy_mask), 32'd0);

    // Stall on rt=9 interrupted by a taken branch
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 9, 0);
    next_cycle();
    drive(1, 0, 9, 0, 1, 0, 0, 0);
    chk("br9_c1_stall", 32'(bus.stall_if), 32'd1);
    next_cycle();
    drive(1, 0, 9, 0, 1, 0, 0, 1);
    chk("br9_c2_stall", 32'(bus.stall_if), 32'd0);
    chk("br9_c2_flush", 32'(bus.flush_if_id), 32'd1);
    chk("br9_c2_issue", 32'(bus.issue), 32'd0);
    chk("br9_c2_state", 32'(bus.state), 32'd1);
    chk("br9_c2_scount", 32'(bus.stall_count), 32'd4);
    next_cycle();
    drive(1, 0, 9, 0, 1, 0, 0, 0);
    chk("br9_c3_flush", 32'(bus.flush_if_id), 32'd1);
    chk("br9_c3_stall", 32'(bus.stall_if), 32'd0);
    chk("br9_c3_bubble", 32'(bus.bubble_ex), 32'd1);
    chk("br9_c3_state", 32'(bus.state), 32'd2);
    chk("br9_c3_scount", 32'(bus.stall_count), 32'd4);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("br9_c4_flush", 32'(bus.flush_if_id), 32'd0);
    chk("br9_c4_state", 32'(bus.state), 32'd0);
    chk("br9_c4_scount", 32'(bus.stall_count), 32'd4);

    // Hazard and branch in the same cycle: branch wins
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 10, 0);
    next_cycle();
    drive(1, 10, 0, 1, 0, 0, 0, 1);
    chk("hb_stall", 32'(bus.stall_if), 32'd0);
    chk("hb_flush", 32'(bus.flush_if_id), 32'd1);
    chk("hb_issue", 32'(bus.issue), 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("hb_c2_state", 32'(bus.state), 32'd2);
    chk("hb_c2_flush", 32'(bus.flush_if_id), 32'd1);
    chk("hb_c2_scount", 32'(bus.stall_count), 32'd4);
    next_cycle();
    chk("hb_c3_state", 32'(bus.state), 32'd0);
    chk("hb_c3_flush", 32'(bus.flush_if_id), 32'd0);

    // Reset in the middle of a stall on r12
    next_cycle();
    drive(1, 0, 0, 0, 0, 1, 12, 0);
    next_cycle();
    drive(1, 12, 0, 1, 0, 0, 0, 0);
    chk("mr_c1_stall", 32'(bus.stall_if), 32'd1);
    next_cycle();
    chk("mr_c2_state", 32'(bus.state), 32'd1);
    chk("mr_c2_scount", 32'(bus.stall_count), 32'd5);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("mr_r0_stall", 32'(bus.stall_if), 32'd0);
    chk("mr_r0_issue", 32'(bus.issue), 32'd0);
    chk("mr_r0_bubble", 32'(bus.bubble_ex), 32'd1);
    next_cycle();
    chk("mr_r1_issue", 32'(bus.issue), 32'd0);
    chk("mr_r1_busy", 32'(bus.busy_mask), 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.busy_mask), 32'd0);
    chk("mr_state", 32'(bus.state), 32'd0);
    chk("mr_scount", 32'(bus.stall_count), 32'd0);
    chk("mr_cons_issue", 32'(bus.issue), 32'd1);
    chk("mr_cons_stall", 32'(bus.stall_if), 32'd0);

    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage IF/ID/EX/DM/WB datapath.
- Tracks in-flight register writes with a per-register countdown scoreboard.
- Stalls IF and IF/ID and injects bubbles into ID/EX on RAW hazards.
- Squashes wrong-path instructions after a taken branch resolves in EX.

Parameters:
NUM_REGS, 32, architectural register count (register 0 hardwired zero)
REG_ADDR_W, 5, register address width
WB_LATENCY, 3, cycles from issue into ID/EX until the WB write is visible to an ID read; range 1..7
FLUSH_CYCLES, 2, squash cycles after a taken branch; range 1..3

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a valid instruction
id_rs  in  REG_ADDR_W  source register 1
id_rt  in  REG_ADDR_W  source register 2
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_reg_write  in  1  instruction writes a register
id_rd  in  REG_ADDR_W  destination register (after reg_dst selection)
ex_branch_taken  in  1  branch in EX resolved taken this cycle
stall_if  out  1  hold PC and IF/ID
bubble_ex  out  1  load NOP (all controls 0) into ID/EX
flush_if_id  out  1  invalidate IF/ID contents
issue  out  1  ID instruction advances into ID/EX this cycle
busy_mask  out  NUM_REGS  bit r = 1 while the counter for r is nonzero
stall_count  out  16  saturating count of stall cycles
state  out  2  00 RUN, 01 STALL, 10 FLUSH

Behaviour:
Scoreboard:
- One counter per register, 3 bits wide.
- On an edge with issue=1, id_reg_write=1 and id_rd!=0: counter[id_rd] <= WB_LATENCY. This reloads even if the counter is nonzero (WAW: the latest writer wins).
- Every other nonzero counter decrements by 1 per edge.
- Counter 0 is never loaded; busy_mask[0]=0 always.
- Only issued instructions load counters. Bubbled or flushed instructions never do.
- Counters keep decrementing in every state.

Hazard (combinational):
- hazard = id_valid & ((id_uses_rs & id_rs!=0 & busy[id_rs]) | (id_uses_rt & id_rt!=0 & busy[id_rt])).

Outputs (combinational on state and inputs), priority top-down:
- reset=1: issue=0, stall_if=0, flush_if_id=0, bubble_ex=1.
- state=FLUSH: flush_if_id=1, bubble_ex=1, stall_if=0, issue=0. ex_branch_taken is ignored.
- ex_branch_taken=1 (RUN or STALL): flush_if_id=1, bubble_ex=1, stall_if=0, issue=0. Branch overrides hazard.
- hazard=1: stall_if=1, bubble_ex=1, issue=0, flush_if_id=0.
- Otherwise: issue=id_valid, bubble_ex=~id_valid, stall_if=0, flush_if_id=0.

FSM (registered):
- RUN/STALL with ex_branch_taken: FLUSH if FLUSH_CYCLES>1, with fcnt <= FLUSH_CYCLES-2. If FLUSH_CYCLES=1, go to RUN.
- RUN/STALL with hazard: STALL.
- RUN/STALL otherwise: RUN.
- FLUSH: if fcnt=0 go to RUN, else fcnt decrements.
- Total flush_if_id-high cycles per taken branch = FLUSH_CYCLES.

Timing:
- Producer issued at the edge ending cycle t: its rd is busy during cycles t+1..t+WB_LATENCY.
- A dependent instruction in ID at t+1 issues at cycle t+WB_LATENCY+1.

stall_count:
- +1 on each edge with stall_if=1; saturates at 0xFFFF.

Reset (synchronous):
- All counters 0, fcnt 0, state RUN, stall_count 0.
- busy_mask=0 after the first reset edge.
- Reset mid-STALL or mid-FLUSH abandons the operation with no residual effects.

Test Plan:
- Reset held 2 cycles mid-operation -> busy_mask=0, state=00, stall_count=0; issue=0 and bubble_ex=1 while reset=1.
- Issue rd=8 with reg_write at cycle 0; consumer rs=8 (uses_rs) in ID from cycle 1 -> stall_if=1 in cycles 1-3, issue=1 in cycle 4, stall_count=3, busy_mask[8] clear at cycle 4.
- Producer rd=0, consumer rs=0 next cycle -> no stall, busy_mask=0, issue=1.
- Stall on rt=9 in progress, ex_branch_taken pulsed 1 cycle -> stall_if=0, flush_if_id=1 for exactly 2 cycles, state 10 then 00; stall_count frozen during flush.
- Issue rd=5 at cycle 0 and again at cycle 1 -> busy_mask[5]=1 in cycles 1-4, 0 at cycle 5.
- Hazard and ex_branch_taken asserted in the same cycle -> flush wins: stall_if=0, flush_if_id=1, no stall_count increment.
